// File: rtl/hazard_pkg.sv
// Shared constants for the hazard/forwarding controller: mux select encodings
// and the Tnew/Tuse values the decoder hands in.
package hazard_pkg;

  localparam int unsigned RAW_DEF = 5;
  localparam int unsigned TW_DEF  = 2;

  // D-stage operand mux
  localparam logic [1:0] SEL_GRF = 2'd0;
  localparam logic [1:0] SEL_E   = 2'd1;
  localparam logic [1:0] SEL_M   = 2'd2;
  localparam logic [1:0] SEL_W   = 2'd3;

  // E/M-stage operand muxes
  localparam logic [1:0] SEL_PIPE  = 2'd0;
  localparam logic [1:0] SEL_FWD_M = 2'd1;
  localparam logic [1:0] SEL_FWD_W = 2'd2;

  localparam logic [1:0] TNEW_LINK = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

endpackage

// File: rtl/fwd_sel.sv
// Priority match of one source register against up to three producer entries.
// sel_c = 0 for no hit, otherwise 1 + index of the nearest ready producer.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int unsigned RAW = RAW_DEF,
  parameter int unsigned TW  = TW_DEF
) (
  input  logic [RAW-1:0] src,
  input  logic [2:0]     en,
  input  logic [RAW-1:0] a3_0,
  input  logic [TW-1:0]  tnew_0,
  input  logic [RAW-1:0] a3_1,
  input  logic [TW-1:0]  tnew_1,
  input  logic [RAW-1:0] a3_2,
  input  logic [TW-1:0]  tnew_2,
  output logic [1:0]     sel_c
);

  function automatic logic hit(input logic e, input logic [RAW-1:0] s,
                               input logic [RAW-1:0] a3, input logic [TW-1:0] tnew);
    return e && (a3 == s) && (tnew == '0);
  endfunction

  // $0 is never forwarded; a nonzero src match implies a nonzero a3
  always_comb begin
    sel_c = 2'd0;
    if (src != '0) begin
      if (hit(en[0], src, a3_0, tnew_0))      sel_c = 2'd1;
      else if (hit(en[1], src, a3_1, tnew_1)) sel_c = 2'd2;
      else if (hit(en[2], src, a3_2, tnew_2)) sel_c = 2'd3;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall and forwarding-select generator for the 5-stage MIPS pipeline, driven
// by a shadow pipeline of {rs, rt, a3, tnew} for the E, M and W stages.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned RAW = RAW_DEF,
  parameter int unsigned TW  = TW_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [RAW-1:0] d_rs,
  input  logic [RAW-1:0] d_rt,
  input  logic [TW-1:0]  d_tuse_rs,
  input  logic [TW-1:0]  d_tuse_rt,
  input  logic [RAW-1:0] d_a3,
  input  logic [TW-1:0]  d_tnew,
  input  logic           d_is_md,
  input  logic           md_busy,
  output logic           stall,
  output logic [1:0]     fwd_d_rs_sel,
  output logic [1:0]     fwd_d_rt_sel,
  output logic [1:0]     fwd_e_rs_sel,
  output logic [1:0]     fwd_e_rt_sel,
  output logic           fwd_m_rt_sel
);

  typedef struct packed {
    logic [RAW-1:0] rs;
    logic [RAW-1:0] rt;
    logic [RAW-1:0] a3;
    logic [TW-1:0]  tnew;
  } entry_t;

  entry_t e_q, m_q, w_q;
  entry_t e_d, m_d, w_d;
  logic [1:0] m_rt_sel;
  logic       w_unused;

  function automatic logic [TW-1:0] tdec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  function automatic logic raw_hz(input logic [RAW-1:0] src, input logic [TW-1:0] tuse,
                                  input entry_t x);
    return (x.a3 != '0) && (x.a3 == src) && (tuse != TW'(TUSE_NONE)) && (tuse < x.tnew);
  endfunction

  assign stall = (md_busy & d_is_md)
               | raw_hz(d_rs, d_tuse_rs, e_q) | raw_hz(d_rs, d_tuse_rs, m_q)
               | raw_hz(d_rt, d_tuse_rt, e_q) | raw_hz(d_rt, d_tuse_rt, m_q);

  // Advance the shadow pipeline; tnew counts down and saturates at 0
  always_comb begin
    w_d      = m_q;
    w_d.tnew = tdec(m_q.tnew);
    m_d      = e_q;
    m_d.tnew = tdec(e_q.tnew);
    e_d      = '0;
    if (!stall) e_d = '{rs: d_rs, rt: d_rt, a3: d_a3, tnew: d_tnew};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  fwd_sel #(.RAW(RAW), .TW(TW)) u_d_rs (
    .src(d_rs), .en(3'b111),
    .a3_0(e_q.a3), .tnew_0(e_q.tnew),
    .a3_1(m_q.a3), .tnew_1(m_q.tnew),
    .a3_2(w_q.a3), .tnew_2(w_q.tnew),
    .sel_c(fwd_d_rs_sel)
  );

  fwd_sel #(.RAW(RAW), .TW(TW)) u_d_rt (
    .src(d_rt), .en(3'b111),
    .a3_0(e_q.a3), .tnew_0(e_q.tnew),
    .a3_1(m_q.a3), .tnew_1(m_q.tnew),
    .a3_2(w_q.a3), .tnew_2(w_q.tnew),
    .sel_c(fwd_d_rt_sel)
  );

  fwd_sel #(.RAW(RAW), .TW(TW)) u_e_rs (
    .src(e_q.rs), .en(3'b011),
    .a3_0(m_q.a3), .tnew_0(m_q.tnew),
    .a3_1(w_q.a3), .tnew_1(w_q.tnew),
    .a3_2('0),     .tnew_2('0),
    .sel_c(fwd_e_rs_sel)
  );

  fwd_sel #(.RAW(RAW), .TW(TW)) u_e_rt (
    .src(e_q.rt), .en(3'b011),
    .a3_0(m_q.a3), .tnew_0(m_q.tnew),
    .a3_1(w_q.a3), .tnew_1(w_q.tnew),
    .a3_2('0),     .tnew_2('0),
    .sel_c(fwd_e_rt_sel)
  );

  fwd_sel #(.RAW(RAW), .TW(TW)) u_m_rt (
    .src(m_q.rt), .en(3'b001),
    .a3_0(w_q.a3), .tnew_0(w_q.tnew),
    .a3_1('0),     .tnew_1('0),
    .a3_2('0),     .tnew_2('0),
    .sel_c(m_rt_sel)
  );

  assign fwd_m_rt_sel = (m_rt_sel == SEL_FWD_M);

  // W sources are kept for debug visibility only
  assign w_unused = ^{w_q.rs, w_q.rt};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stall and forwarding selects checked against
// hand-computed values for ALU, load-use, priority, $0 and mult/div cases.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_a3;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_is_md, md_busy;
  logic       stall;
  logic [1:0] fwd_d_rs_sel, fwd_d_rt_sel, fwd_e_rs_sel, fwd_e_rt_sel;
  logic       fwd_m_rt_sel;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_a3(d_a3), .d_tnew(d_tnew),
    .d_is_md(d_is_md), .md_busy(md_busy),
    .stall(stall),
    .fwd_d_rs_sel(fwd_d_rs_sel), .fwd_d_rt_sel(fwd_d_rt_sel),
    .fwd_e_rs_sel(fwd_e_rs_sel), .fwd_e_rt_sel(fwd_e_rt_sel),
    .fwd_m_rt_sel(fwd_m_rt_sel)
  );

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [4:0] rs, input logic [4:0] rt,
                     input logic [1:0] trs, input logic [1:0] trt,
                     input logic [4:0] a3, input logic [1:0] tn,
                     input logic md, input logic busy);
    d_rs = rs; d_rt = rt; d_tuse_rs = trs; d_tuse_rt = trt;
    d_a3 = a3; d_tnew = tn; d_is_md = md; md_busy = busy;
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drv(0, 0, 3, 3, 0, 0, 0, 0);
    repeat (2) cyc();
    reset = 1'b0;

    // Reset state
    drv(8, 0, 0, 3, 0, 0, 0, 0);
    chk("rst_stall", 8'(stall), 8'd0);
    chk("rst_d_rs",  8'(fwd_d_rs_sel), 8'd0);
    chk("rst_d_rt",  8'(fwd_d_rt_sel), 8'd0);
    chk("rst_e_rs",  8'(fwd_e_rs_sel), 8'd0);
    chk("rst_e_rt",  8'(fwd_e_rt_sel), 8'd0);
    chk("rst_m_rt",  8'(fwd_m_rt_sel), 8'd0);

    // ALU result consumed in D: one stall, then forward from M
    do_reset();
    drv(1, 2, 1, 1, 8, TNEW_ALU, 0, 0);
    chk("alu_issue_stall", 8'(stall), 8'd0);
    cyc();
    drv(8, 0, 0, 0, 0, 0, 0, 0);
    chk("alu_stall", 8'(stall), 8'd1);
    chk("alu_stall_d_rs", 8'(fwd_d_rs_sel), 8'd0);
    cyc();
    chk("alu_release", 8'(stall), 8'd0);
    chk("alu_d_rs_m", 8'(fwd_d_rs_sel), 8'(SEL_M));
    chk("alu_d_rt", 8'(fwd_d_rt_sel), 8'd0);

    // Load-use: one stall, then E-stage forward from W; then store-data paths
    do_reset();
    drv(4, 0, 1, 3, 9, TNEW_LOAD, 0, 0);
    chk("lu_issue_stall", 8'(stall), 8'd0);
    cyc();
    drv(3, 9, 1, 1, 10, TNEW_ALU, 0, 0);
    chk("lu_stall", 8'(stall), 8'd1);
    cyc();
    chk("lu_release", 8'(stall), 8'd0);
    chk("lu_release_d_rt", 8'(fwd_d_rt_sel), 8'd0);
    cyc();
    drv(0, 10, 3, 2, 0, 0, 0, 0);
    chk("lu_e_rt_w", 8'(fwd_e_rt_sel), 8'(SEL_FWD_W));
    chk("lu_e_rs", 8'(fwd_e_rs_sel), 8'd0);
    chk("sw_issue_stall", 8'(stall), 8'd0);
    cyc();
    drv(0, 0, 3, 3, 0, 0, 0, 0);
    chk("sw_e_rt_m", 8'(fwd_e_rt_sel), 8'(SEL_FWD_M));
    cyc();
    chk("sw_m_rt_w", 8'(fwd_m_rt_sel), 8'd1);
    chk("sw_e_rt_nop", 8'(fwd_e_rt_sel), 8'd0);

    // Priority between two link writes of $31, then walk down M and W
    do_reset();
    drv(0, 0, 3, 3, 31, TNEW_LINK, 0, 0);
    cyc();
    drv(0, 0, 3, 3, 31, TNEW_LINK, 0, 0);
    cyc();
    drv(31, 0, 0, 3, 0, 0, 0, 0);
    chk("pri_d_rs_e", 8'(fwd_d_rs_sel), 8'(SEL_E));
    chk("pri_stall", 8'(stall), 8'd0);
    cyc();
    chk("pri_d_rs_m", 8'(fwd_d_rs_sel), 8'(SEL_M));
    cyc();
    chk("pri_d_rs_w", 8'(fwd_d_rs_sel), 8'(SEL_W));

    // Load into $0 is inert
    do_reset();
    drv(4, 0, 1, 3, 0, TNEW_LOAD, 0, 0);
    cyc();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk("z_stall", 8'(stall), 8'd0);
    chk("z_d_rs", 8'(fwd_d_rs_sel), 8'd0);
    chk("z_d_rt", 8'(fwd_d_rt_sel), 8'd0);

    // Mult/div busy for 5 cycles, reset asserted in cycle 3
    do_reset();
    drv(1, 2, 1, 1, 5, TNEW_ALU, 0, 0);
    chk("md_pre_stall", 8'(stall), 8'd0);
    cyc();
    drv(5, 6, 1, 1, 0, 0, 1, 1);
    chk("md_c1_stall", 8'(stall), 8'd1);
    cyc();
    chk("md_c2_stall", 8'(stall), 8'd1);
    chk("md_c2_e_a3", 8'(dut.e_q.a3), 8'd0);
    chk("md_c2_m_a3", 8'(dut.m_q.a3), 8'd5);
    cyc();
    chk("md_c3_stall", 8'(stall), 8'd1);
    chk("md_c3_e_a3", 8'(dut.e_q.a3), 8'd0);
    chk("md_c3_w_a3", 8'(dut.w_q.a3), 8'd5);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    chk("md_c4_stall", 8'(stall), 8'd1);
    chk("md_c4_w_a3", 8'(dut.w_q.a3), 8'd0);
    chk("md_c4_m_a3", 8'(dut.m_q.a3), 8'd0);
    cyc();
    chk("md_c5_stall", 8'(stall), 8'd1);
    chk("md_c5_e_a3", 8'(dut.e_q.a3), 8'd0);
    cyc();
    drv(0, 0, 3, 3, 0, 0, 0, 0);
    chk("md_done_stall", 8'(stall), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
